// File: rtl/alu_core.sv
// alu_core: registered 8-bit ALU stage with a one-cycle done pulse.
// Define ALU_MUL_EN to build the 8-cycle shift-add multiplier for opcode 1001.
module alu_core (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] w_SrcA,
   input  logic [7:0] w_SrcB,
   input  logic [3:0] alu_ctrl,
   input  logic       start,
   output logic [7:0] w_ALUResult,
   output logic       zero,
   output logic       negative,
   output logic       carry,
   output logic       overflow,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_SRL = 4'b0111;
   localparam logic [3:0] OP_SRA = 4'b1000;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1001;
`endif

   logic [7:0]         res_c;
   logic               c_c;
   logic               v_c;
   logic [2:0]         sh;
   logic [8:0]         sum;
   logic [8:0]         dif;
   logic [15:0]        sll_t;
   logic [15:0]        srl_t;
   logic signed [15:0] sra_t;

   // Shifts run in a 16-bit window so the bit just past the byte is the carry.
   always_comb begin
      sh    = w_SrcB[2:0];
      sum   = {1'b0, w_SrcA} + {1'b0, w_SrcB};
      dif   = {1'b0, w_SrcA} - {1'b0, w_SrcB};
      sll_t = {8'h00, w_SrcA} << sh;
      srl_t = {w_SrcA, 8'h00} >> sh;
      sra_t = $signed({w_SrcA, 8'h00}) >>> sh;
      res_c = 8'h00;
      c_c   = 1'b0;
      v_c   = 1'b0;
      unique case (alu_ctrl)
         OP_ADD: begin
            res_c = sum[7:0];
            c_c   = sum[8];
            v_c   = (w_SrcA[7] == w_SrcB[7]) && (sum[7] != w_SrcA[7]);
         end
         OP_SUB: begin
            res_c = dif[7:0];
            c_c   = ~dif[8];
            v_c   = (w_SrcA[7] != w_SrcB[7]) && (dif[7] != w_SrcA[7]);
         end
         OP_AND: res_c = w_SrcA & w_SrcB;
         OP_OR:  res_c = w_SrcA | w_SrcB;
         OP_XOR: res_c = w_SrcA ^ w_SrcB;
         OP_SLT: res_c = {7'd0, $signed(w_SrcA) < $signed(w_SrcB)};
         OP_SLL: begin
            res_c = sll_t[7:0];
            c_c   = sll_t[8];
         end
         OP_SRL: begin
            res_c = srl_t[15:8];
            c_c   = srl_t[7];
         end
         OP_SRA: begin
            res_c = sra_t[15:8];
            c_c   = sra_t[7];
         end
         default: ;
      endcase
   end

   logic [7:0] res_q, res_d;
   logic [3:0] flg_q, flg_d;
   logic       done_q, done_d;

`ifdef ALU_MUL_EN
   typedef enum logic {IDLE, MUL} state_t;

   state_t      state_q, state_d;
   logic [15:0] ma_q, ma_d;
   logic [15:0] acc_q, acc_d, acc_n;
   logic [7:0]  mb_q, mb_d;
   logic [2:0]  cnt_q, cnt_d;
`endif

   // flg_* packs {zero, negative, carry, overflow}.
   always_comb begin
      res_d  = res_q;
      flg_d  = flg_q;
      done_d = 1'b0;
`ifdef ALU_MUL_EN
      state_d = state_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      acc_n   = acc_q + (mb_q[0] ? ma_q : 16'h0000);
      if (state_q == MUL) begin
         acc_d = acc_n;
         ma_d  = ma_q << 1;
         mb_d  = mb_q >> 1;
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            state_d = IDLE;
            res_d   = acc_n[7:0];
            flg_d   = {acc_n[7:0] == 8'h00, acc_n[7], |acc_n[15:8], 1'b0};
            done_d  = 1'b1;
         end
      end else if (start && alu_ctrl == OP_MUL) begin
         state_d = MUL;
         ma_d    = {8'h00, w_SrcA};
         mb_d    = w_SrcB;
         acc_d   = 16'h0000;
         cnt_d   = 3'd0;
      end else
`endif
      if (start) begin
         res_d  = res_c;
         flg_d  = {res_c == 8'h00, res_c[7], c_c, v_c};
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q  <= 8'h00;
         flg_q  <= 4'h0;
         done_q <= 1'b0;
`ifdef ALU_MUL_EN
         state_q <= IDLE;
         ma_q    <= 16'h0000;
         mb_q    <= 8'h00;
         acc_q   <= 16'h0000;
         cnt_q   <= 3'd0;
`endif
      end else begin
         res_q  <= res_d;
         flg_q  <= flg_d;
         done_q <= done_d;
`ifdef ALU_MUL_EN
         state_q <= state_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign w_ALUResult = res_q;
   assign zero        = flg_q[3];
   assign negative    = flg_q[2];
   assign carry       = flg_q[1];
   assign overflow    = flg_q[0];
   assign done        = done_q;
`ifdef ALU_MUL_EN
   assign busy        = (state_q == MUL);
`else
   assign busy        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core.
// Works with or without ALU_MUL_EN defined.
module tb_alu_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic [3:0] op;
   logic [7:0] res;
   logic       z, n, c, v;
   logic       busy, done;

   alu_core dut (
      .clk        (clk),
      .rst        (rst),
      .w_SrcA     (a),
      .w_SrcB     (b),
      .alu_ctrl   (op),
      .start      (start),
      .w_ALUResult(res),
      .zero       (z),
      .negative   (n),
      .carry      (c),
      .overflow   (v),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

`ifdef ALU_MUL_EN
   localparam int MUL_LAT = 9;
`else
   localparam int MUL_LAT = 1;
`endif

   typedef struct {
      int         due;
      logic [7:0] res;
      logic [3:0] flg;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         errors  = 0;
   int         checks  = 0;
   int         cyc     = 0;
   int         mul_beg = 0;
   int         mul_end = 0;
   bit         mon_on  = 1'b0;
   logic [3:0] ro;
   logic [7:0] ra, rb;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Reference: returns {result, zero, negative, carry, overflow}.
   function automatic logic [11:0] model(input logic [3:0] o,
                                         input logic [7:0] x,
                                         input logic [7:0] y);
      int         r, sx, sy, s;
      logic       cf, vf;
      logic [7:0] t;
      r  = 0;
      cf = 1'b0;
      vf = 1'b0;
      sx = x[7] ? int'(x) - 256 : int'(x);
      sy = y[7] ? int'(y) - 256 : int'(y);
      t  = x;
      case (o)
         4'd0: begin
            r  = int'(x) + int'(y);
            cf = r > 255;
            s  = sx + sy;
            vf = (s > 127) || (s < -128);
         end
         4'd1: begin
            r  = int'(x) - int'(y);
            cf = x >= y;
            s  = sx - sy;
            vf = (s > 127) || (s < -128);
         end
         4'd2: r = int'(x & y);
         4'd3: r = int'(x | y);
         4'd4: r = int'(x ^ y);
         4'd5: r = (sx < sy) ? 1 : 0;
         4'd6: begin
            repeat (int'(y[2:0])) begin
               cf = t[7];
               t  = t << 1;
            end
            r = int'(t);
         end
         4'd7: begin
            repeat (int'(y[2:0])) begin
               cf = t[0];
               t  = t >> 1;
            end
            r = int'(t);
         end
         4'd8: begin
            repeat (int'(y[2:0])) begin
               cf = t[0];
               t  = {t[7], t[7:1]};
            end
            r = int'(t);
         end
`ifdef ALU_MUL_EN
         4'd9: begin
            r  = int'(x) * int'(y);
            cf = r > 255;
         end
`endif
         default: r = 0;
      endcase
      t = r[7:0];
      return {t, t == 8'h00, t[7], cf, vf};
   endfunction

   task automatic go_k(input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] er,
                       input logic [3:0] ef);
      exp_t e;
      @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      e.due = cyc + ((o == 4'd9) ? MUL_LAT : 1);
      e.res = er;
      e.flg = ef;
      sb.push_back(e);
      if (o == 4'd9 && MUL_LAT > 1) begin
         mul_beg = cyc + 1;
         mul_end = cyc + MUL_LAT;
      end
   endtask

   task automatic go(input logic [3:0] o, input logic [7:0] x,
                     input logic [7:0] y);
      logic [11:0] m;
      m = model(o, x, y);
      go_k(o, x, y, m[11:4], m[3:0]);
   endtask

   // A start that the DUT must drop because it is busy.
   task automatic ign(input logic [3:0] o, input logic [7:0] x,
                      input logic [7:0] y);
      @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         start = 1'b0;
         a     = 8'($urandom);
         b     = 8'($urandom);
         op    = 4'($urandom);
      end
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (mon_on) begin
         chk("busy", 32'(busy), 32'(cyc >= mul_beg && cyc < mul_end));
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'(done), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("latency", 32'(cyc), 32'(mon_e.due));
               chk("result", 32'(res), 32'(mon_e.res));
               chk("flags", 32'({z, n, c, v}), 32'(mon_e.flg));
            end
         end else if (sb.size() > 0 && cyc >= sb[0].due) begin
            chk("missing_done", 32'(done), 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      op    = 4'h0;
      repeat (2) @(negedge clk);
      chk("rst_result", 32'(res), 32'h0);
      chk("rst_flags", 32'({z, n, c, v}), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      rst    = 1'b0;
      mon_on = 1'b1;

      go_k(4'h0, 8'h7F, 8'h01, 8'h80, 4'b0101);
      idle(1);
      go_k(4'h1, 8'h05, 8'h05, 8'h00, 4'b1010);
      go_k(4'h1, 8'h03, 8'h05, 8'hFE, 4'b0100);
      go_k(4'h8, 8'h81, 8'h01, 8'hC0, 4'b0110);
      go_k(4'h6, 8'h81, 8'h09, 8'h02, 4'b0010);
      go_k(4'h7, 8'h81, 8'h00, 8'h81, 4'b0100);
      go_k(4'h5, 8'h80, 8'h01, 8'h01, 4'b0000);
      go_k(4'hF, 8'hAA, 8'h55, 8'h00, 4'b1000);
      idle(2);

`ifdef ALU_MUL_EN
      go_k(4'h9, 8'h0C, 8'h0D, 8'h9C, 4'b0100);
      idle(2);
      ign(4'h0, 8'h11, 8'h22);
      idle(5);
      go_k(4'h9, 8'h10, 8'h10, 8'h00, 4'b1010);
      idle(8);
`else
      go_k(4'h9, 8'h0C, 8'h0D, 8'h00, 4'b1000);
      idle(3);
`endif

      go_k(4'h0, 8'hF0, 8'h20, 8'h10, 4'b0010);
      idle(1);
      go(4'h9, 8'h0C, 8'h0D);
      idle(3);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      sb.delete();
      if (mul_end > cyc + 1) mul_end = cyc + 1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_result", 32'(res), 32'h0);
      chk("abort_flags", 32'({z, n, c, v}), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      repeat (10) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'h0);
      end

      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         rb = 8'($urandom);
         go(ro, ra, rb);
         if (ro == 4'd9) idle(8);
         else if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(2);
      for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
